// File: rtl/sprite_pkg.sv
// Shared pixel-path types: RGB565 layout and packing of two pixels per frame-buffer word.
package sprite_pkg;

  localparam int R_WIDTH         = 5;
  localparam int G_WIDTH         = 6;
  localparam int B_WIDTH         = 5;
  localparam int PIXEL_WIDTH     = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int PIXELS_PER_WORD = 2;
  localparam int WORD_WIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD;

  typedef struct packed {
    logic [R_WIDTH-1:0] r;
    logic [G_WIDTH-1:0] g;
    logic [B_WIDTH-1:0] b;
  } pixel_t;

  // sel=0 picks the pixel displayed first (low half), sel=1 the second.
  function automatic pixel_t word_pixel(input logic [WORD_WIDTH-1:0] word, input logic sel);
    pixel_t p;
    if (sel) begin
      p = pixel_t'(word[WORD_WIDTH-1:PIXEL_WIDTH]);
    end else begin
      p = pixel_t'(word[PIXEL_WIDTH-1:0]);
    end
    return p;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty and a synchronous flush.
module pixel_fifo
  import sprite_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full_r && !flush;
  assign do_pop_s  = pop && !empty_r && !flush;

  // Occupancy for the next cycle; full/empty are registered from it.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - (AW+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers and status flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_COUNT);
      empty_r <= (count_nxt_s == '0);
    end
  end

  // Storage array carries no reset; validity is tracked by count_r alone.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pixel_unpacker.sv
// Buffers packed RGB565 word pairs and hands out one pixel per request, flagging underflow.
module pixel_unpacker
  import sprite_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] BLANK_COLOR = 16'h0000,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic                 frame_start,
  input  logic                 next_pixel_please,
  output logic [15:0]          pixel,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_cnt
);

  logic [WORD_WIDTH-1:0] head_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  half_r;
  pixel_t                pixel_r;
  logic                  underflow_r;
  logic [CNT_WIDTH-1:0]  underflow_cnt_r;

  // The head word leaves the FIFO only once its second pixel is taken.
  assign push_s = word_valid && !full_s && !frame_start;
  assign pop_s  = next_pixel_please && !empty_s && half_r && !frame_start;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (push_s),
    .push_data (word_data),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Pixel output register, half-word selector and underflow bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_r          <= 1'b0;
      pixel_r         <= pixel_t'(BLANK_COLOR);
      underflow_r     <= 1'b0;
      underflow_cnt_r <= '0;
    end else if (frame_start) begin
      half_r  <= 1'b0;
      pixel_r <= pixel_t'(BLANK_COLOR);
    end else if (next_pixel_please) begin
      if (!empty_s) begin
        pixel_r <= word_pixel(head_s, half_r);
        half_r  <= ~half_r;
      end else begin
        pixel_r     <= pixel_t'(BLANK_COLOR);
        underflow_r <= 1'b1;
        if (underflow_cnt_r != {CNT_WIDTH{1'b1}}) begin
          underflow_cnt_r <= underflow_cnt_r + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign word_ready    = !full_s;
  assign pixel         = pixel_r;
  assign underflow     = underflow_r;
  assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized scoreboard bench for pixel_unpacker against a pixel-queue reference model.
module tb_pixel_unpacker;

  localparam int          DEPTH = 16;
  localparam int          CW    = 4;
  localparam logic [15:0] BLANK = 16'h0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   word_data = 32'h0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          frame_start = 1'b0;
  logic          next_pixel_please = 1'b0;
  logic [15:0]   pixel;
  logic          underflow;
  logic [CW-1:0] underflow_cnt;

  always #5 clk = ~clk;

  pixel_unpacker #(
    .DEPTH       (DEPTH),
    .BLANK_COLOR (BLANK),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .word_data         (word_data),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .frame_start       (frame_start),
    .next_pixel_please (next_pixel_please),
    .pixel             (pixel),
    .underflow         (underflow),
    .underflow_cnt     (underflow_cnt)
  );

  typedef struct {
    logic [15:0]   pixel;
    logic          uf;
    logic [CW-1:0] cnt;
    logic          ready;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pixq[$];   // pixels still to be shown, in display order
  logic [15:0] m_pix;
  bit          m_uf;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int words_held();
    return (pixq.size() + 1) / 2;
  endfunction

  // One clock of stimulus plus the model's prediction of the state after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit f);
    exp_t e;
    bit   full;
    bit   empty;
    @(negedge clk);
    word_valid        = v;
    word_data         = d;
    next_pixel_please = r;
    frame_start       = f;
    full  = (words_held() == DEPTH);
    empty = (pixq.size() == 0);
    if (f) begin
      pixq.delete();
      m_pix = BLANK;
    end else begin
      if (r) begin
        if (!empty) begin
          m_pix = pixq.pop_front();
        end else begin
          m_pix = BLANK;
          m_uf  = 1'b1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      if (v && !full) begin
        pixq.push_back(d[15:0]);
        pixq.push_back(d[31:16]);
      end
    end
    e.pixel = m_pix;
    e.uf    = m_uf;
    e.cnt   = m_cnt[CW-1:0];
    e.ready = (words_held() != DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    pixq.delete();
    m_pix = BLANK;
    m_uf  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pixel"}, 32'(pixel), 32'(BLANK));
    check({tag, "_underflow"}, 32'(underflow), 32'h0);
    check({tag, "_cnt"}, 32'(underflow_cnt), 32'h0);
    check({tag, "_ready"}, 32'(word_ready), 32'h1);
  endtask

  // Reset raised between edges; outputs must settle before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    word_valid = 1'b0;
    next_pixel_please = 1'b0;
    frame_start = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares each predicted post-edge state against the DUT.
  exp_t mon_e;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pixel", 32'(pixel), 32'(mon_e.pixel));
      check("underflow", 32'(underflow), 32'(mon_e.uf));
      check("underflow_cnt", 32'(underflow_cnt), 32'(mon_e.cnt));
      check("word_ready", 32'(word_ready), 32'(mon_e.ready));
    end
  end

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic split order: low half first.
    step(1'b1, 32'hF800_001F, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Fill to full, source holds the 17th word, then consume one pair.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Underflow on empty, then recovery.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h07E0_07E0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Flush mid-word with concurrent push and request.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hAAAA_5555, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Counter saturation.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-burst, then resume.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, (i > 1), 1'b0);
    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, (i > 0), 1'b0);
    idle();

    // Random traffic with occasional flushes and one more reset.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) async_reset();
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 59) == 0));
    end
    idle();

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
